// File: rtl/lab_pkg.sv
// Shared types for the LAB-to-RGB path: rounding/op selectors, a signed-magnitude
// word, and the add/sub of a signed term onto the non-negative Fy.
package lab_pkg;

    // Wide enough for any DSIZE up to 32 plus the carry bit.
    localparam int SM_W = 33;

    typedef enum logic [1:0] {
        RM_CEIL    = 2'd0,
        RM_TRUNC   = 2'd1,
        RM_NEAREST = 2'd2
    } rmode_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic            sign;
        logic [SM_W-1:0] mag;
    } sm_t;

    // fy + (f_neg ? -f : f); equal magnitudes give +0.
    function automatic sm_t sm_addsub(input logic [SM_W-2:0] fy,
                                      input logic [SM_W-2:0] f,
                                      input logic            f_neg);
        sm_t r;
        if (!f_neg) begin
            r.sign = 1'b0;
            r.mag  = {1'b0, fy} + {1'b0, f};
        end else if (f > fy) begin
            r.sign = 1'b1;
            r.mag  = {1'b0, f - fy};
        end else begin
            r.sign = 1'b0;
            r.mag  = {1'b0, fy - f};
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_round_sat.sv
// Combinational rescale of one signed-magnitude word: drop CSIZE fraction bits
// with the selected rounding, saturate to OSIZE bits, and clear the sign of zero.
module sm_round_sat
    import lab_pkg::*;
#(
    parameter int     CSIZE = 1,
    parameter int     OSIZE = 16,
    parameter rmode_e RM    = RM_CEIL
) (
    input  sm_t              din,
    output logic [OSIZE-1:0] mag,
    output logic             sign,
    output logic             sat
);

    localparam logic [CSIZE-1:0] HALF = CSIZE'(32'd1 << (CSIZE - 1));

    logic [SM_W-1:0]  q;
    logic [SM_W-1:0]  rnd;
    logic [CSIZE-1:0] rem;
    logic             inc;

    always_comb begin
        q   = din.mag >> CSIZE;
        rem = din.mag[CSIZE-1:0];
        inc = 1'b0;
        case (RM)
            RM_CEIL:    inc = (rem != '0);
            RM_NEAREST: inc = (rem >= HALF);
            default:    inc = 1'b0;
        endcase
        // q is at most 2^(SM_W-1)-1 here, so the increment cannot wrap.
        rnd  = q + SM_W'(inc);
        sat  = ((rnd >> OSIZE) != '0);
        mag  = sat ? '1 : rnd[OSIZE-1:0];
        sign = din.sign & (rnd != '0);
    end

endmodule

// File: rtl/fn_ffn_pipe.sv
// f(X)/f(Z) combiner: S1 forms Fy +/- Fx and Fy +/- Fz in sign-magnitude,
// S2 rounds and saturates all three channels; two-stage valid/ready pipe.
module fn_ffn_pipe
    import lab_pkg::*;
#(
    parameter int    DSIZE = 16,
    parameter int    CSIZE = 1,
    parameter int    OSIZE = 16,
    parameter int    TSIZE = 2,
    parameter string X_OP  = "ADD",
    parameter string Z_OP  = "SUB",
    parameter string RMODE = "CEIL"
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSIZE-1:0] Fx,
    input  logic [DSIZE-1:0] Fy,
    input  logic [DSIZE-1:0] Fz,
    input  logic             sign_Fx,
    input  logic             sign_Fz,
    input  logic [TSIZE-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OSIZE-1:0] FFx,
    output logic [OSIZE-1:0] FFy,
    output logic [OSIZE-1:0] FFz,
    output logic             sign_FFx,
    output logic             sign_FFz,
    output logic             sat,
    output logic [TSIZE-1:0] out_tag
);

    localparam op_e    X_SEL = (X_OP == "SUB") ? OP_SUB : OP_ADD;
    localparam op_e    Z_SEL = (Z_OP == "SUB") ? OP_SUB : OP_ADD;
    localparam rmode_e RM    = (RMODE == "TRUNC")   ? RM_TRUNC :
                               (RMODE == "NEAREST") ? RM_NEAREST : RM_CEIL;

    // Handshake: a beat moves on valid & ready. S2 loads when empty or out_ready;
    // S1 loads when empty or S2 loads; in_ready = S1 load enable. Data registers
    // only capture real beats, so outputs hold while out_valid & !out_ready.
    logic s1_valid, s2_valid, s1_load, s2_load;

    assign s2_load   = !s2_valid | out_ready;
    assign s1_load   = !s1_valid | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    sm_t x_sum, z_sum;
    assign x_sum = sm_addsub((SM_W-1)'(Fy), (SM_W-1)'(Fx), sign_Fx ^ (X_SEL == OP_SUB));
    assign z_sum = sm_addsub((SM_W-1)'(Fy), (SM_W-1)'(Fz), sign_Fz ^ (Z_SEL == OP_SUB));

    sm_t              s1_x, s1_z, s1_y;
    logic [DSIZE-1:0] s1_fy;
    logic [TSIZE-1:0] s1_tag;

    assign s1_y = '{sign: 1'b0, mag: SM_W'(s1_fy)};

    logic [OSIZE-1:0] rx_mag, ry_mag, rz_mag;
    logic             rx_sign, rz_sign, ry_sign_unused;
    logic             rx_sat, ry_sat, rz_sat;

    sm_round_sat #(.CSIZE(CSIZE), .OSIZE(OSIZE), .RM(RM)) u_rx (
        .din(s1_x), .mag(rx_mag), .sign(rx_sign), .sat(rx_sat)
    );
    sm_round_sat #(.CSIZE(CSIZE), .OSIZE(OSIZE), .RM(RM)) u_ry (
        .din(s1_y), .mag(ry_mag), .sign(ry_sign_unused), .sat(ry_sat)
    );
    sm_round_sat #(.CSIZE(CSIZE), .OSIZE(OSIZE), .RM(RM)) u_rz (
        .din(s1_z), .mag(rz_mag), .sign(rz_sign), .sat(rz_sat)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_z     <= '0;
            s1_fy    <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            FFx      <= '0;
            FFy      <= '0;
            FFz      <= '0;
            sign_FFx <= 1'b0;
            sign_FFz <= 1'b0;
            sat      <= 1'b0;
            out_tag  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_x   <= x_sum;
                    s1_z   <= z_sum;
                    s1_fy  <= Fy;
                    s1_tag <= in_tag;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    FFx      <= rx_mag;
                    FFy      <= ry_mag;
                    FFz      <= rz_mag;
                    sign_FFx <= rx_sign;
                    sign_FFz <= rz_sign;
                    sat      <= rx_sat | ry_sat | rz_sat;
                    out_tag  <= s1_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_fn_ffn_pipe.sv
// Bench for fn_ffn_pipe: three instances (CEIL/16, TRUNC/16, NEAREST/12) share
// stimulus; a signed-integer model feeds an expected queue checked at negedge.
module tb_fn_ffn_pipe;
    localparam int TS = 3;
    localparam int BW = TS + 1 + 1 + 16 + 16 + 1 + 16;  // one packed beat
    localparam int W  = 3 * BW;                          // c, t, n instances

    logic          clk, rst;
    logic          in_valid, out_ready;
    logic [15:0]   Fx, Fy, Fz;
    logic          sign_Fx, sign_Fz;
    logic [TS-1:0] in_tag;

    logic          ir_c, ir_t, ir_n, ov_c, ov_t, ov_n;
    logic [15:0]   ffx_c, ffy_c, ffz_c, ffx_t, ffy_t, ffz_t;
    logic [11:0]   ffx_n, ffy_n, ffz_n;
    logic          sx_c, sz_c, sat_c, sx_t, sz_t, sat_t, sx_n, sz_n, sat_n;
    logic [TS-1:0] tag_c, tag_t, tag_n;

    fn_ffn_pipe #(.TSIZE(TS), .RMODE("CEIL")) dut_c (
        .clock(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c),
        .Fx(Fx), .Fy(Fy), .Fz(Fz), .sign_Fx(sign_Fx), .sign_Fz(sign_Fz), .in_tag(in_tag),
        .out_valid(ov_c), .out_ready(out_ready), .FFx(ffx_c), .FFy(ffy_c), .FFz(ffz_c),
        .sign_FFx(sx_c), .sign_FFz(sz_c), .sat(sat_c), .out_tag(tag_c)
    );
    fn_ffn_pipe #(.TSIZE(TS), .RMODE("TRUNC")) dut_t (
        .clock(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_t),
        .Fx(Fx), .Fy(Fy), .Fz(Fz), .sign_Fx(sign_Fx), .sign_Fz(sign_Fz), .in_tag(in_tag),
        .out_valid(ov_t), .out_ready(out_ready), .FFx(ffx_t), .FFy(ffy_t), .FFz(ffz_t),
        .sign_FFx(sx_t), .sign_FFz(sz_t), .sat(sat_t), .out_tag(tag_t)
    );
    fn_ffn_pipe #(.TSIZE(TS), .OSIZE(12), .RMODE("NEAREST")) dut_n (
        .clock(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_n),
        .Fx(Fx), .Fy(Fy), .Fz(Fz), .sign_Fx(sign_Fx), .sign_Fz(sign_Fz), .in_tag(in_tag),
        .out_valid(ov_n), .out_ready(out_ready), .FFx(ffx_n), .FFy(ffy_n), .FFz(ffz_n),
        .sign_FFx(sx_n), .sign_FFz(sz_n), .sat(sat_n), .out_tag(tag_n)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit pat_en = 1'b0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---------------- reference model ----------------
    // Returns {sat, sign, mag}; mode 0=CEIL 1=TRUNC 2=NEAREST, one fraction bit dropped.
    function automatic logic [17:0] rs(input longint v, input int mode, input int osz);
        longint m, q, lim;
        logic s, st;
        m   = (v < 0) ? -v : v;
        lim = (longint'(1) << osz) - 1;
        if (mode == 0)      q = (m + 1) / 2;
        else if (mode == 1) q = m / 2;
        else                q = (m + 1) / 2;
        st = (q > lim);
        if (st) q = lim;
        s = (v < 0) && (q != 0);
        return {st, s, q[15:0]};
    endfunction

    function automatic logic [BW-1:0] model(input int mode, input int osz);
        longint vx, vz;
        logic [17:0] rx, ry, rz;
        vx = longint'(Fy) + (sign_Fx ? -longint'(Fx) : longint'(Fx));   // X adds
        vz = longint'(Fy) + (sign_Fz ? longint'(Fz) : -longint'(Fz));   // Z subtracts
        rx = rs(vx, mode, osz);
        ry = rs(longint'(Fy), mode, osz);
        rz = rs(vz, mode, osz);
        return {in_tag, rx[17] | ry[17] | rz[17], rx[16], rx[15:0], ry[15:0], rz[16], rz[15:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs, exp_w;

    always_comb obs = {tag_c, sat_c, sx_c, ffx_c, ffy_c, sz_c, ffz_c,
                       tag_t, sat_t, sx_t, ffx_t, ffy_t, sz_t, ffz_t,
                       tag_n, sat_n, sx_n, 4'h0, ffx_n, 4'h0, ffy_n, sz_n, 4'h0, ffz_n};

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            total++;
            assert (ir_c === !(exp_q.size() == 2 && !out_ready))
            else begin
                bad++;
                $error("FAIL in_ready obs=%0b exp=%0b", ir_c, !(exp_q.size() == 2 && !out_ready));
            end
            if (ov_c === 1'b1) begin
                total++;
                assert (exp_q.size() > 0)
                else begin
                    bad++;
                    $error("FAIL unexpected_beat obs=%0h exp=none", obs);
                end
                if (exp_q.size() > 0) begin
                    exp_w = exp_q[0];
                    for (int i = 0; i < 3; i++) begin
                        total++;
                        assert (obs[i*BW +: BW] === exp_w[i*BW +: BW])
                        else begin
                            bad++;
                            $error("FAIL beat_inst%0d obs=%0h exp=%0h", 2 - i,
                                   obs[i*BW +: BW], exp_w[i*BW +: BW]);
                        end
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && ir_c) exp_q.push_back({model(0, 16), model(1, 16), model(2, 12)});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pat_en) out_ready = pat[cyc % 4];
    endtask

    task automatic chk(input string name, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", name, o, e);
        end
    endtask

    task automatic send(input logic [15:0] fy, input logic [15:0] fx, input logic [15:0] fz,
                        input logic sx, input logic sz, input logic [TS-1:0] tag);
        bit acc;
        Fy = fy; Fx = fx; Fz = fz; sign_Fx = sx; sign_Fz = sz; in_tag = tag;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = ir_c;
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        Fx = '0; Fy = '0; Fz = '0; sign_Fx = 1'b0; sign_Fz = 1'b0; in_tag = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_in_ready", 64'(ir_c), 64'd1);
        chk("rst_out_valid", 64'(ov_c), 64'd0);
        chk("rst_data", {ffx_c, ffy_c, ffz_c, 3'(tag_c), sx_c, sz_c, sat_c, 10'd0}, 64'd0);

        // Fy=1000, Fx=-300: latency and value
        send(16'd1000, 16'd300, 16'd0, 1'b1, 1'b0, 3'd1);
        chk("lat_early", 64'(ov_c), 64'd0);
        step();
        chk("lat_2cyc", 64'(ov_c), 64'd1);
        chk("ffx_350", 64'(ffx_c), 64'd350);
        chk("sfx_350", 64'(sx_c), 64'd0);
        chk("sat_350", 64'(sat_c), 64'd0);

        // Fy=1000, Fx=-1200 -> -100; Fz equal to Fy under SUB -> +0
        send(16'd1000, 16'd1200, 16'd1000, 1'b1, 1'b0, 3'd2);
        step();
        chk("ffx_100", 64'(ffx_c), 64'd100);
        chk("sfx_neg", 64'(sx_c), 64'd1);
        chk("ffz_zero", 64'(ffz_c), 64'd0);
        chk("sfz_zero", 64'(sz_c), 64'd0);

        // Fy=1001, Fx=0 -> rounding modes
        send(16'd1001, 16'd0, 16'd0, 1'b0, 1'b0, 3'd3);
        step();
        chk("ceil_x", 64'(ffx_c), 64'd501);
        chk("ceil_y", 64'(ffy_c), 64'd501);
        chk("trunc_x", 64'(ffx_t), 64'd500);
        chk("trunc_y", 64'(ffy_t), 64'd500);
        chk("near_x", 64'(ffx_n), 64'd501);
        chk("near_y", 64'(ffy_n), 64'd501);

        // OSIZE=12 saturation
        send(16'h2000, 16'd0, 16'h0010, 1'b0, 1'b1, 3'd4);
        step();
        chk("sat_ffz", 64'(ffz_n), 64'hFFF);
        chk("sat_ffy", 64'(ffy_n), 64'hFFF);
        chk("sat_flag", 64'(sat_n), 64'd1);
        chk("nosat16", 64'(sat_c), 64'd0);
        chk("ffz16", 64'(ffz_c), 64'h1008);

        // 8-beat stream, tag = index, out_ready 1,0,0,1
        pat_en = 1'b1;
        for (int i = 0; i < 8; i++)
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), 1'($urandom), 1'($urandom), 3'(i));
        drain();

        // longer random stream under the same stall pattern
        for (int i = 0; i < 40; i++)
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), 1'($urandom), 1'($urandom), 3'($urandom));
        drain();
        pat_en = 1'b0;

        // fill pipe while stalled, then reset mid-stream
        out_ready = 1'b0;
        send(16'd500, 16'd7, 16'd9, 1'b0, 1'b1, 3'd5);
        send(16'd600, 16'd8, 16'd3, 1'b1, 1'b0, 3'd6);
        chk("full_in_ready", 64'(ir_c), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(ov_c), 64'd0);
        chk("mid_rst_data", {ffx_c, ffy_c, ffz_c, 3'(tag_c), sx_c, sz_c, sat_c, 10'd0}, 64'd0);
        chk("mid_rst_ready", 64'(ir_c), 64'd1);
        out_ready = 1'b1;
        send(16'd40, 16'd2, 16'd4, 1'b0, 1'b0, 3'd7);
        chk("post_rst_early", 64'(ov_c), 64'd0);
        step();
        chk("post_rst_valid", 64'(ov_c), 64'd1);
        chk("post_rst_tag", 64'(tag_c), 64'd7);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fn_ffn_pipe.md
Name: fn_ffn_pipe

Overview:
- Parametrised successor to the f(X)/f(Z) combiner in the LAB-to-RGB path.
- Forms FFx = Fy ± Fx and FFz = Fy ± Fz in sign-magnitude, then rescales by dropping CSIZE fractional bits with a selectable rounding mode and saturation.
- Forwards FFy and a sideband tag.
- Adds a valid/ready pipeline with backpressure, so it sits between the Fn stage and the inverse-f/XYZ stage without external delay matching.

Parameters:
- DSIZE, 16, magnitude width of Fx/Fy/Fz inputs.
- CSIZE, 1, LSBs dropped after add/sub; 0 < CSIZE < DSIZE.
- OSIZE, 16, output magnitude width; OSIZE <= DSIZE+1-CSIZE.
- TSIZE, 2, sideband tag width (e.g. hsync/vsync); passed through.
- X_OP, "ADD", FFx = Fy + sx*Fx ("ADD") or Fy - sx*Fx ("SUB").
- Z_OP, "SUB", same rule for FFz.
- RMODE, "CEIL", magnitude rounding: "CEIL" (away from zero), "TRUNC", "NEAREST" (half away from zero).

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- Fx  in  DSIZE  magnitude of x term.
- Fy  in  DSIZE  magnitude of y term (always non-negative).
- Fz  in  DSIZE  magnitude of z term.
- sign_Fx  in  1  1 = Fx negative.
- sign_Fz  in  1  1 = Fz negative.
- in_tag  in  TSIZE  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- FFx  out  OSIZE  result magnitude.
- FFy  out  OSIZE  Fy rescaled with the same rounding rule.
- FFz  out  OSIZE  result magnitude.
- sign_FFx  out  1  1 = FFx negative.
- sign_FFz  out  1  1 = FFz negative.
- sat  out  1  any of FFx/FFy/FFz saturated this beat.
- out_tag  out  TSIZE  delayed in_tag.

Behaviour:
- Two register stages: S1 (add/sub), S2 (round/saturate). Outputs come straight from S2 registers.
- S1, x channel, signed term t = (sign_Fx XOR (X_OP=="SUB")) ? -Fx : +Fx; result r = Fy + t, computed as a DSIZE+1-bit magnitude plus sign.
  - Same-sign case: magnitude = Fy + Fx.
  - Otherwise: magnitude = |Fy - Fx|, negative iff Fx > Fy.
  - Equal magnitudes give 0, positive.
- z channel follows the same rules using Z_OP. Fy is carried in S1 unchanged.
- S2 acts on each magnitude m: q = m >> CSIZE, rem = m[CSIZE-1:0].
  - CEIL: q+1 if rem != 0.
  - TRUNC: q.
  - NEAREST: q+1 if rem >= 2^(CSIZE-1).
- Rounding applies to the magnitude, never the sign.
- If the rounded value is >= 2^OSIZE, the output is 2^OSIZE-1 and sat=1.
- A zero magnitude after rounding forces its sign to 0.
- Handshake: a beat transfers on valid & ready.
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - in_ready = !S1_valid | S2_load.
- Throughput is 1 beat/cycle. Latency from input acceptance to out_valid is exactly 2 cycles when out_ready=1.
- While out_valid=1 and out_ready=0, all outputs hold stable and no beat is lost or duplicated. A full pipe holds 2 beats.
- Simultaneous accept and emit in the same cycle is legal and keeps the pipe full.
- Reset: valid bits, all data/sign/sat/tag registers clear to 0, and in_ready=1 in the cycle after reset release. Reset mid-stream discards in-flight beats.
- Inputs are sampled only on the accept cycle. Values presented while in_ready=0 are ignored.

Decomposition:
- Shared package lab_pkg: rounding-mode constants (RM_CEIL, RM_TRUNC, RM_NEAREST), op constants (OP_ADD, OP_SUB), and a signed-magnitude struct {sign, mag}.
- Natural sub-module: sm_round_sat (combinational round + saturate of one magnitude), instantiated 3x in S2; it replaces the older ceiling instances.
- The S1 add/sub is a function in lab_pkg, used 2x.

Test Plan (DSIZE=16, CSIZE=1, OSIZE=16, CEIL unless noted):
- Fy=1000, Fx=300, sign_Fx=1 -> FFx=350, sign_FFx=0, out_valid exactly 2 cycles after accept, sat=0.
- Fy=1000, Fx=1200, sign_Fx=1 -> FFx=100, sign_FFx=1. Fz=1000, sign_Fz=0, Z_OP SUB -> FFz=0, sign_FFz=0.
- Fy=1001, Fx=0 -> FFx=501 for CEIL and NEAREST, 500 for TRUNC. FFy matches FFx in each mode.
- OSIZE=12, Fy=0x2000, Fz=0x10, sign_Fz=1 -> FFz=0xFFF, FFy=0xFFF, sat=1.
- Stream of 8 beats, tag = index, out_ready toggled 1,0,0,1 pattern -> all 8 emerge in order, no drops or duplicates, outputs stable while stalled, in_ready=0 only when pipe is full and stalled.
- Assert rst with 2 beats in flight -> next cycle out_valid=0, all outputs 0. After release, a new beat emerges 2 cycles later.
